// File: rtl/scope_pkg.sv
// Shared types and defaults for the scope acquisition controller.
package scope_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 10;

    // Five capture states need three encoding bits.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRETRIG  = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POSTTRIG = 3'd3,
        ST_DONE     = 3'd4
    } cap_state_t;

    // Busy covers every state in which samples are being written.
    function automatic logic state_is_busy(cap_state_t s);
        return (s == ST_PRETRIG) || (s == ST_ARMED) || (s == ST_POSTTRIG);
    endfunction

endpackage

// File: rtl/trigger_capture_trig_detect.sv
// Level/slope trigger detector: remembers the previous strobed sample and flags
// a one-cycle hit when the current strobed sample crosses the level.
module trig_detect #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic              i_stb,
    input  logic [DATA_W-1:0] i_sample,
    input  logic [DATA_W-1:0] i_level,
    input  logic              i_slope,
    output logic              o_hit
);

    logic [DATA_W-1:0] r_prev;
    logic              r_prev_valid;
    logic              w_rise;
    logic              w_fall;

    // Track the previous strobed sample; a new capture forgets history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (i_clear) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (i_en && i_stb) begin
            r_prev       <= i_sample;
            r_prev_valid <= 1'b1;
        end
    end

    // Combinational compare so the hit lines up with the sample being written.
    always_comb begin
        w_rise = (r_prev < i_level) && (i_sample >= i_level);
        w_fall = (r_prev > i_level) && (i_sample <= i_level);
        o_hit  = i_en && i_stb && r_prev_valid && (i_slope ? w_fall : w_rise);
    end

endmodule

// File: rtl/trigger_capture.sv
// Scope acquisition controller: writes strobed ADC samples into a circular
// capture RAM, keeps pre_depth samples ahead of a level/slope trigger and
// flags done when the full pre+post record is in the buffer.
// Optional build macro AUTO_TRIG_EN adds an auto-trigger timeout while ARMED.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no capture, waiting for arm
// PRETRIG  | filling pre-trigger history, trigger not evaluated
// ARMED    | writing circularly, waiting for trigger
// POSTTRIG | writing post-trigger samples until the record is full
// DONE     | record complete, trig_addr and done held for readout
module trigger_capture
    import scope_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_stb,
    input  logic [DATA_W-1:0] sample,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [ADDR_W-1:0] pre_depth,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              done
`ifdef AUTO_TRIG_EN
    ,
    input  logic [15:0]       auto_timeout,
    output logic              auto_fired
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    cap_state_t        r_state;
    cap_state_t        w_state_next;

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_pre_cnt;
    logic [ADDR_W:0]   r_post_cnt;
    logic [DATA_W-1:0] r_level;
    logic              r_slope;
    logic [ADDR_W-1:0] r_pre_depth;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_trig_addr;

    logic              w_busy;
    logic              w_start;
    logic              w_write;
    logic              w_hit;
    logic              w_auto_hit;
    logic              w_trig;
    logic [ADDR_W:0]   w_post_target;

    trig_detect #(.DATA_W(DATA_W)) u_trig_detect (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  (w_start),
        .i_en     (w_busy),
        .i_stb    (sample_stb),
        .i_sample (sample),
        .i_level  (r_level),
        .i_slope  (r_slope),
        .o_hit    (w_hit)
    );

`ifdef AUTO_TRIG_EN
    logic [15:0] r_auto_cnt;
    logic        r_auto_fired;

    assign w_auto_hit = (r_state == ST_ARMED) && sample_stb && (auto_timeout != 16'd0)
                        && ((r_auto_cnt + 16'd1) == auto_timeout);
    assign auto_fired = r_auto_fired;

    // Count strobes spent in ARMED; remember whether the trigger was forced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_auto_cnt   <= '0;
            r_auto_fired <= 1'b0;
        end else if (w_start || abort) begin
            r_auto_cnt   <= '0;
            r_auto_fired <= 1'b0;
        end else if ((r_state == ST_ARMED) && w_write) begin
            r_auto_cnt <= r_auto_cnt + 16'd1;
            if (w_trig && !w_hit) begin
                r_auto_fired <= 1'b1;
            end
        end
    end
`else
    assign w_auto_hit = 1'b0;
`endif

    // Control terms shared by the next-state logic and the datapath.
    always_comb begin
        w_busy        = state_is_busy(r_state);
        w_start       = arm && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_write       = sample_stb && w_busy && !abort;
        w_trig        = (r_state == ST_ARMED) && w_write && (w_hit || w_auto_hit);
        w_post_target = (ADDR_W+1)'(DEPTH) - {1'b0, r_pre_depth};
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        w_state_next = (pre_depth == '0) ? ST_ARMED : ST_PRETRIG;
                    end
                end
                ST_PRETRIG: begin
                    if (w_write && ((r_pre_cnt + ADDR_W'(1)) == r_pre_depth)) begin
                        w_state_next = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // With pre_depth = DEPTH-1 the trigger sample fills the last slot.
                    if (w_trig) begin
                        w_state_next = (w_post_target == (ADDR_W+1)'(1)) ? ST_DONE : ST_POSTTRIG;
                    end
                end
                ST_POSTTRIG: begin
                    if (w_write && ((r_post_cnt + (ADDR_W+1)'(1)) == w_post_target)) begin
                        w_state_next = ST_DONE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Write pipeline, pointer, counters and latched capture settings.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
            r_level     <= '0;
            r_slope     <= 1'b0;
            r_pre_depth <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_trig_addr <= '0;
        end else begin
            r_wr_en <= w_write;
            if (w_write) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= sample;
                r_ptr     <= r_ptr + ADDR_W'(1);
            end
            if (w_write && (r_state == ST_PRETRIG)) begin
                r_pre_cnt <= r_pre_cnt + ADDR_W'(1);
            end
            if (w_trig) begin
                r_trig_addr <= r_ptr;
                r_post_cnt  <= (ADDR_W+1)'(1);
            end else if (w_write && (r_state == ST_POSTTRIG)) begin
                r_post_cnt <= r_post_cnt + (ADDR_W+1)'(1);
            end
            if (w_start) begin
                r_ptr       <= '0;
                r_pre_cnt   <= '0;
                r_post_cnt  <= '0;
                r_level     <= trig_level;
                r_slope     <= trig_slope;
                r_pre_depth <= pre_depth;
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign trig_addr = r_trig_addr;
    assign busy      = w_busy;
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_trigger_capture.sv
// Bench for trigger_capture (DATA_W=8, ADDR_W=4). Expected RAM writes are queued
// as stimulus is issued; a negedge monitor pops and compares each write.
// Build with AUTO_TRIG_EN defined to include the auto-trigger scenario.
module tb_trigger_capture;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sample_stb = 1'b0;
    logic [7:0] sample = 8'h00;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] trig_level = 8'h00;
    logic       trig_slope = 1'b0;
    logic [3:0] pre_depth = 4'd0;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] trig_addr;
    logic       busy;
    logic       done;
`ifdef AUTO_TRIG_EN
    logic [15:0] auto_timeout = 16'd0;
    logic        auto_fired;
`endif

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic       done;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    trigger_capture #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_stb (sample_stb),
        .sample     (sample),
        .arm        (arm),
        .abort      (abort),
        .trig_level (trig_level),
        .trig_slope (trig_slope),
        .pre_depth  (pre_depth),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .trig_addr  (trig_addr),
        .busy       (busy),
        .done       (done)
`ifdef AUTO_TRIG_EN
        ,
        .auto_timeout (auto_timeout),
        .auto_fired   (auto_fired)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every observed write must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n && wr_en) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h expected no write at %0t",
                         wr_addr, wr_data, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("wr_addr", int'(wr_addr), int'(e.addr));
                check("wr_data", int'(wr_data), int'(e.data));
                check("wr_done", int'(done), int'(e.done));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] s, input logic [3:0] a, input logic d);
        exp_t e;
        e.addr = a;
        e.data = s;
        e.done = d;
        q.push_back(e);
        sample     = s;
        sample_stb = 1'b1;
        @(posedge clk);
        #1;
        sample_stb = 1'b0;
    endtask

    task automatic send_nw(input logic [7:0] s);
        sample     = s;
        sample_stb = 1'b1;
        @(posedge clk);
        #1;
        sample_stb = 1'b0;
    endtask

    task automatic do_arm(input logic [7:0] lvl, input logic slp, input logic [3:0] pre);
        trig_level = lvl;
        trig_slope = slp;
        pre_depth  = pre;
        arm        = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_trig_addr", int'(trig_addr), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1. Rising ramp, pre_depth=4: trigger on 0x80 at addr 8, 20 writes, last at addr 3.
        do_arm(8'h80, 1'b0, 4'd4);
        for (int i = 0; i < 20; i++) begin
            send(8'(i * 16), 4'(i), (i == 19));
            if (i == 8) check("ramp_trig_addr_mid", int'(trig_addr), 8);
            if (i == 18) check("ramp_busy_mid", int'(busy), 1);
        end
        check("ramp_done", int'(done), 1);
        check("ramp_trig_addr", int'(trig_addr), 8);
        check("ramp_busy_end", int'(busy), 0);
        send_nw(8'h33);
        check("ramp_done_hold", int'(done), 1);

        // 2a. Falling: 0x90,0x80 -> trigger on second sample (addr 1).
        do_arm(8'h80, 1'b1, 4'd0);
        check("fall_done_cleared", int'(done), 0);
        send(8'h90, 4'd0, 1'b0);
        send(8'h80, 4'd1, 1'b0);
        send(8'h80, 4'd2, 1'b0);
        send(8'h70, 4'd3, 1'b0);
        check("fall_trig_addr_a", int'(trig_addr), 1);
        do_abort();
        check("fall_abort_busy", int'(busy), 0);
        // 2b. Falling: 0x90,0x90,0x70 -> trigger on 0x70 (addr 2).
        do_arm(8'h80, 1'b1, 4'd0);
        send(8'h90, 4'd0, 1'b0);
        send(8'h90, 4'd1, 1'b0);
        check("fall_no_trig_yet", int'(trig_addr), 1);
        send(8'h70, 4'd2, 1'b0);
        check("fall_trig_addr_b", int'(trig_addr), 2);
        do_abort();

        // 3. Crossing inside PRETRIG is ignored.
        do_arm(8'h80, 1'b0, 4'd8);
        send(8'h00, 4'd0, 1'b0);
        send(8'h70, 4'd1, 1'b0);
        send(8'h90, 4'd2, 1'b0);
        send(8'h10, 4'd3, 1'b0);
        send(8'h90, 4'd4, 1'b0);
        check("pretrig_busy", int'(busy), 1);
        check("pretrig_trig_addr", int'(trig_addr), 2);
        do_abort();

        // 4a. abort+arm in ARMED with a strobe: IDLE, no write.
        do_arm(8'h80, 1'b0, 4'd0);
        send(8'h00, 4'd0, 1'b0);
        abort      = 1'b1;
        arm        = 1'b1;
        sample     = 8'h55;
        sample_stb = 1'b1;
        @(posedge clk);
        #1;
        abort      = 1'b0;
        arm        = 1'b0;
        sample_stb = 1'b0;
        check("abort_arm_busy", int'(busy), 0);
        check("abort_arm_wr_en", int'(wr_en), 0);
        send_nw(8'h66);
        check("abort_arm_idle", int'(busy), 0);

        // 4b. arm during POSTTRIG ignored; pre_depth=14 leaves two post slots.
        do_arm(8'h80, 1'b0, 4'd14);
        for (int i = 0; i < 14; i++) send(8'h00, 4'(i), 1'b0);
        send(8'h00, 4'd14, 1'b0);
        send(8'hA0, 4'd15, 1'b0);
        check("post_arm_trig_addr", int'(trig_addr), 15);
        arm = 1'b1;
        send(8'h11, 4'd0, 1'b1);
        arm = 1'b0;
        check("post_arm_done", int'(done), 1);
        check("post_arm_trig_hold", int'(trig_addr), 15);

        // 4c. pre_depth=DEPTH-1: trigger sample is the final write.
        do_arm(8'h80, 1'b0, 4'd15);
        for (int i = 0; i < 15; i++) send(8'h00, 4'(i), 1'b0);
        send(8'h10, 4'd15, 1'b0);
        check("max_pre_not_done", int'(done), 0);
        send(8'hFF, 4'd0, 1'b1);
        check("max_pre_trig_addr", int'(trig_addr), 0);
        check("max_pre_done", int'(done), 1);

        // 5. Reset mid-POSTTRIG with a write pending.
        do_arm(8'h80, 1'b0, 4'd0);
        send(8'h00, 4'd0, 1'b0);
        send(8'h90, 4'd1, 1'b0);
        @(negedge clk);
        #1;
        sample     = 8'h77;
        sample_stb = 1'b1;
        reset_n    = 1'b0;
        #1;
        check("rst_mid_wr_en", int'(wr_en), 0);
        check("rst_mid_wr_addr", int'(wr_addr), 0);
        check("rst_mid_wr_data", int'(wr_data), 0);
        check("rst_mid_trig_addr", int'(trig_addr), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        sample_stb = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) send_nw(8'(8'h20 + i));
        check("rst_after_busy", int'(busy), 0);

`ifdef AUTO_TRIG_EN
        // 6. Forced trigger on 5th strobe of constant input.
        auto_timeout = 16'd5;
        do_arm(8'h80, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) send(8'h00, 4'(i), 1'b0);
        check("auto_not_yet", int'(auto_fired), 0);
        send(8'h00, 4'd4, 1'b0);
        check("auto_trig_addr", int'(trig_addr), 4);
        check("auto_fired", int'(auto_fired), 1);
        do_abort();
        check("auto_fired_clr", int'(auto_fired), 0);
        auto_timeout = 16'd0;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
